// File: rtl/cn0363_pkg.sv
// Shared types, constants and helpers for the CN0363 I/Q demodulator.
// Holds width defaults, quadrant encoding, output slice and sine-table generator.
package cn0363_pkg;

    localparam int COEF_WIDTH_DEF     = 16;
    localparam int LUT_ADDR_WIDTH_DEF = 8;
    localparam int SAMPLE_WIDTH       = 24;
    localparam int WORD_WIDTH         = 32;

    typedef enum logic [1:0] {
        QUAD_0   = 2'd0,
        QUAD_90  = 2'd1,
        QUAD_180 = 2'd2,
        QUAD_270 = 2'd3
    } quad_e;

    // Odd quadrants read the quarter wave backwards.
    function automatic logic quad_mirror(input quad_e q);
        return (q == QUAD_90) || (q == QUAD_270);
    endfunction

    // Lower half circle is the negated quarter wave.
    function automatic logic quad_negate(input quad_e q);
        return (q == QUAD_180) || (q == QUAD_270);
    endfunction

    // Output word is the top 32 bits of the full product.
    function automatic logic [WORD_WIDTH-1:0] iq_word(
        input logic signed [63:0] prod,
        input int                 coef_w
    );
        return 32'(prod >>> (coef_w - 8));
    endfunction

    // Quarter-wave entry k with half-entry offset, computed in Q28 fixed
    // point with a Taylor series so elaboration needs no real math.
    // The top entry is held one code below full scale.
    function automatic int lut_entry(
        input int k,
        input int aw,
        input int cw
    );
        longint pi_q = 64'd843314857;
        longint fs;
        longint x;
        longint x2;
        longint term;
        longint sum;
        longint val;
        fs   = (longint'(1) <<< (cw - 1)) - 1;
        x    = (pi_q * longint'(2 * k + 1)) >>> (aw + 2);
        x2   = (x * x) >>> 28;
        term = x;
        sum  = x;
        for (int n = 1; n <= 7; n++) begin
            term = -((term * x2) >>> 28) / longint'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        val = (sum * fs + (longint'(1) <<< 27)) >>> 28;
        if (val > fs - 1) begin
            val = fs - 1;
        end
        return int'(val);
    endfunction

endpackage

// File: rtl/cn0363_sin_lut.sv
// Quarter-wave sine ROM with two registered read ports sharing a clock enable.
// Ports: clk, reset, i_en, i_sin_addr, i_cos_addr -> o_sin, o_cos (unsigned).
module cn0363_sin_lut
    import cn0363_pkg::*;
#(
    parameter int ADDR_WIDTH = LUT_ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = COEF_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_en,
    input  logic [ADDR_WIDTH-1:0] i_sin_addr,
    input  logic [ADDR_WIDTH-1:0] i_cos_addr,
    output logic [DATA_WIDTH-1:0] o_sin,
    output logic [DATA_WIDTH-1:0] o_cos
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] w_rom [DEPTH];
    logic [DATA_WIDTH-1:0] r_sin;
    logic [DATA_WIDTH-1:0] r_cos;

    for (genvar k = 0; k < DEPTH; k++) begin : g_rom
        localparam logic [DATA_WIDTH-1:0] ENTRY =
            DATA_WIDTH'(lut_entry(k, ADDR_WIDTH, DATA_WIDTH));
        assign w_rom[k] = ENTRY;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sin <= '0;
            r_cos <= '0;
        end else if (i_en) begin
            r_sin <= w_rom[i_sin_addr];
            r_cos <= w_rom[i_cos_addr];
        end
    end

    assign o_sin = r_sin;
    assign o_cos = r_cos;

endmodule

// File: rtl/cn0363_iq_demod.sv
// Lock-in I/Q demodulator: joins phase and sample, multiplies by cos/sin.
// Ports: phase/data in (joined handshake), i_q out (I then Q), processing_resetn flush.
module cn0363_iq_demod
    import cn0363_pkg::*;
#(
    parameter int LUT_ADDR_WIDTH = LUT_ADDR_WIDTH_DEF,
    parameter int COEF_WIDTH     = COEF_WIDTH_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        processing_resetn,
    input  logic [31:0] phase,
    input  logic        phase_valid,
    output logic        phase_ready,
    input  logic [23:0] data,
    input  logic        data_valid,
    output logic        data_ready,
    output logic [31:0] i_q,
    output logic        i_q_valid,
    input  logic        i_q_ready
);

    localparam int AW = LUT_ADDR_WIDTH;
    localparam int PW = SAMPLE_WIDTH + COEF_WIDTH;

    logic                         r_s1_valid;
    quad_e                        r_s1_quad;
    logic [AW-1:0]                r_s1_idx;
    logic signed [SAMPLE_WIDTH-1:0] r_s1_sample;

    logic                         r_s2_valid;
    logic                         r_s2_neg_sin;
    logic                         r_s2_neg_cos;
    logic signed [SAMPLE_WIDTH-1:0] r_s2_sample;

    logic                         r_out_valid;
    logic                         r_sel;
    logic [31:0]                  r_i;
    logic [31:0]                  r_q;

    logic w_out_hs;
    logic w_out_done;
    logic w_out_free;
    logic w_s2_free;
    logic w_s1_free;
    logic w_s2_adv;
    logic w_s1_adv;
    logic w_accept;
    logic w_unused;

    quad_e                  w_cos_quad;
    logic [AW-1:0]          w_sin_addr;
    logic [AW-1:0]          w_cos_addr;
    logic [COEF_WIDTH-1:0]  w_lut_sin;
    logic [COEF_WIDTH-1:0]  w_lut_cos;
    logic signed [COEF_WIDTH-1:0] w_sin;
    logic signed [COEF_WIDTH-1:0] w_cos;
    logic signed [PW-1:0]   w_prod_i;
    logic signed [PW-1:0]   w_prod_q;

    assign w_unused = ^phase[29-AW:0];

    // A pair leaves OUT only on the Q handshake.
    assign w_out_hs   = r_out_valid & i_q_ready;
    assign w_out_done = w_out_hs & r_sel;
    assign w_out_free = ~r_out_valid | w_out_done;
    assign w_s2_free  = ~r_s2_valid | w_out_free;
    assign w_s1_free  = ~r_s1_valid | w_s2_free;

    // Data enables are gated by the flush so data registers hold.
    assign w_s2_adv = r_s2_valid & w_out_free & processing_resetn;
    assign w_s1_adv = r_s1_valid & w_s2_free & processing_resetn;
    assign w_accept = phase_valid & data_valid & w_s1_free & processing_resetn;

    assign phase_ready = data_valid & w_s1_free & processing_resetn;
    assign data_ready  = phase_valid & w_s1_free & processing_resetn;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid  <= 1'b0;
            r_s2_valid  <= 1'b0;
            r_out_valid <= 1'b0;
            r_sel       <= 1'b0;
        end else if (!processing_resetn) begin
            r_s1_valid  <= 1'b0;
            r_s2_valid  <= 1'b0;
            r_out_valid <= 1'b0;
            r_sel       <= 1'b0;
        end else begin
            r_s1_valid  <= w_accept | (r_s1_valid & ~w_s1_adv);
            r_s2_valid  <= w_s1_adv | (r_s2_valid & ~w_s2_adv);
            r_out_valid <= w_s2_adv | (r_out_valid & ~w_out_done);
            if (w_out_hs) begin
                r_sel <= ~r_sel;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_quad   <= QUAD_0;
            r_s1_idx    <= '0;
            r_s1_sample <= '0;
        end else if (w_accept) begin
            r_s1_quad   <= quad_e'(phase[31:30]);
            r_s1_idx    <= phase[29 -: AW];
            r_s1_sample <= {~data[23], data[22:0]};
        end
    end

    assign w_cos_quad = quad_e'(r_s1_quad + 2'd1);
    assign w_sin_addr = quad_mirror(r_s1_quad) ? ~r_s1_idx : r_s1_idx;
    assign w_cos_addr = quad_mirror(w_cos_quad) ? ~r_s1_idx : r_s1_idx;

    cn0363_sin_lut #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (COEF_WIDTH)
    ) u_lut (
        .clk        (clk),
        .reset      (reset),
        .i_en       (w_s1_adv),
        .i_sin_addr (w_sin_addr),
        .i_cos_addr (w_cos_addr),
        .o_sin      (w_lut_sin),
        .o_cos      (w_lut_cos)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s2_neg_sin <= 1'b0;
            r_s2_neg_cos <= 1'b0;
            r_s2_sample  <= '0;
        end else if (w_s1_adv) begin
            r_s2_neg_sin <= quad_negate(r_s1_quad);
            r_s2_neg_cos <= quad_negate(w_cos_quad);
            r_s2_sample  <= r_s1_sample;
        end
    end

    assign w_sin = r_s2_neg_sin ? -$signed(w_lut_sin) : $signed(w_lut_sin);
    assign w_cos = r_s2_neg_cos ? -$signed(w_lut_cos) : $signed(w_lut_cos);

    assign w_prod_i = PW'(r_s2_sample) * PW'(w_cos);
    assign w_prod_q = PW'(r_s2_sample) * PW'(w_sin);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_i <= '0;
            r_q <= '0;
        end else if (w_s2_adv) begin
            r_i <= iq_word(64'(w_prod_i), COEF_WIDTH);
            r_q <= iq_word(64'(w_prod_q), COEF_WIDTH);
        end
    end

    assign i_q       = r_sel ? r_q : r_i;
    assign i_q_valid = r_out_valid;

endmodule

// File: tb/tb_cn0363_iq_demod.sv
// Directed self-checking bench for cn0363_iq_demod.
// Hand-computed I/Q words from T[0]=101 and T[255]=32766.
module tb_cn0363_iq_demod;

    logic        clk = 1'b0;
    logic        reset;
    logic        processing_resetn;
    logic [31:0] phase;
    logic        phase_valid;
    logic        phase_ready;
    logic [23:0] data;
    logic        data_valid;
    logic        data_ready;
    logic [31:0] i_q;
    logic        i_q_valid;
    logic        i_q_ready;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cn0363_iq_demod dut (
        .clk               (clk),
        .reset             (reset),
        .processing_resetn (processing_resetn),
        .phase             (phase),
        .phase_valid       (phase_valid),
        .phase_ready       (phase_ready),
        .data              (data),
        .data_valid        (data_valid),
        .data_ready        (data_ready),
        .i_q               (i_q),
        .i_q_valid         (i_q_valid),
        .i_q_ready         (i_q_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] p, input logic [23:0] d,
                         input logic v);
        phase       = p;
        data        = d;
        phase_valid = v;
        data_valid  = v;
    endtask

    task automatic cycles_to_valid(output int n);
        n = 0;
        while (!i_q_valid && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        n_tests++;
        if (i_q !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_iq: got %h expected %h", i_q, 32'h0);
        end
        n_tests++;
        if (i_q_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid: got %b expected 0", i_q_valid);
        end
        n_tests++;
        if (phase_ready !== 1'b0 || data_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready: got %b%b expected 00",
                     phase_ready, data_ready);
        end
        reset = 1'b0;
        tick();
        n_tests++;
        if (i_q_valid !== 1'b0 || i_q !== 32'h0) begin
            n_fail++;
            $display("FAIL post_reset: got %b/%h expected 0/0",
                     i_q_valid, i_q);
        end
    endtask

    task automatic test_join();
        drive(32'h0, 24'hC00000, 1'b0);
        phase_valid = 1'b1;
        #1;
        n_tests++;
        if (phase_ready !== 1'b0 || data_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL join_phase_only: got %b%b expected 01",
                     phase_ready, data_ready);
        end
        phase_valid = 1'b0;
        data_valid  = 1'b1;
        #1;
        n_tests++;
        if (phase_ready !== 1'b1 || data_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL join_data_only: got %b%b expected 10",
                     phase_ready, data_ready);
        end
        repeat (4) tick();
        data_valid = 1'b0;
        n_tests++;
        if (i_q_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL join_no_accept: got %b expected 0", i_q_valid);
        end
    endtask

    task automatic test_vectors();
        logic [31:0] vp [6] = '{32'h0000_0000, 32'h8000_0000, 32'h4000_0000,
                                32'hC000_0000, 32'h1234_5678, 32'h3FC0_0000};
        logic [23:0] vd [6] = '{24'hC00000, 24'hC00000, 24'hC00000,
                                24'hC00000, 24'h800000, 24'h400000};
        logic [31:0] ei [6] = '{32'h1FFF8000, 32'hE0008000, 32'hFFE6C000,
                                32'h00194000, 32'h00000000, 32'hFFE6C000};
        logic [31:0] eq [6] = '{32'h00194000, 32'hFFE6C000, 32'h1FFF8000,
                                32'hE0008000, 32'h00000000, 32'hE0008000};
        int n;
        i_q_ready = 1'b1;
        for (int v = 0; v < 6; v++) begin
            drive(vp[v], vd[v], 1'b1);
            #1;
            n_tests++;
            if (phase_ready !== 1'b1 || data_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL vec%0d_ready: got %b%b expected 11",
                         v, phase_ready, data_ready);
            end
            tick();
            drive(32'h0, 24'h0, 1'b0);
            cycles_to_valid(n);
            n_tests++;
            if (n !== 2) begin
                n_fail++;
                $display("FAIL vec%0d_latency: got %0d expected 2", v, n);
            end
            n_tests++;
            if (i_q !== ei[v]) begin
                n_fail++;
                $display("FAIL vec%0d_I: got %h expected %h", v, i_q, ei[v]);
            end
            tick();
            n_tests++;
            if (i_q_valid !== 1'b1 || i_q !== eq[v]) begin
                n_fail++;
                $display("FAIL vec%0d_Q: got %b/%h expected 1/%h",
                         v, i_q_valid, i_q, eq[v]);
            end
            tick();
            n_tests++;
            if (i_q_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL vec%0d_drain: got %b expected 0",
                         v, i_q_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ph [4] = '{32'h0000_0000, 32'h8000_0000,
                                32'h4000_0000, 32'hC000_0000};
        logic [31:0] es [6] = '{32'h1FFF8000, 32'h00194000,
                                32'hE0008000, 32'hFFE6C000,
                                32'hFFE6C000, 32'h1FFF8000};
        int   idx = 0;
        logic hs;
        i_q_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (idx < 4) drive(ph[idx], 24'hC00000, 1'b1);
            else         drive(32'h0, 24'h0, 1'b0);
            #1;
            hs = phase_ready & data_ready & phase_valid;
            @(posedge clk);
            #1;
            if (hs) idx++;
        end
        n_tests++;
        if (idx !== 3) begin
            n_fail++;
            $display("FAIL bp_accepts: got %0d expected 3", idx);
        end
        #1;
        n_tests++;
        if (phase_ready !== 1'b0 || data_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_ready_low: got %b%b expected 00",
                     phase_ready, data_ready);
        end
        n_tests++;
        if (i_q_valid !== 1'b1 || i_q !== es[0]) begin
            n_fail++;
            $display("FAIL bp_hold: got %b/%h expected 1/%h",
                     i_q_valid, i_q, es[0]);
        end
        drive(32'h0, 24'h0, 1'b0);
        i_q_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            n_tests++;
            if (i_q_valid !== 1'b1 || i_q !== es[k]) begin
                n_fail++;
                $display("FAIL bp_word%0d: got %b/%h expected 1/%h",
                         k, i_q_valid, i_q, es[k]);
            end
            tick();
        end
        n_tests++;
        if (i_q_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_empty: got %b expected 0", i_q_valid);
        end
    endtask

    task automatic test_flush();
        int n;
        i_q_ready = 1'b1;
        drive(32'h0, 24'hC00000, 1'b1);
        #1;
        tick();
        drive(32'h0, 24'h0, 1'b0);
        cycles_to_valid(n);
        n_tests++;
        if (i_q !== 32'h1FFF8000) begin
            n_fail++;
            $display("FAIL flush_i0: got %h expected %h", i_q, 32'h1FFF8000);
        end
        tick();
        processing_resetn = 1'b0;
        drive(32'h8000_0000, 24'hC00000, 1'b1);
        #1;
        n_tests++;
        if (phase_ready !== 1'b0 || data_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_ready: got %b%b expected 00",
                     phase_ready, data_ready);
        end
        tick();
        n_tests++;
        if (i_q_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_valid: got %b expected 0", i_q_valid);
        end
        processing_resetn = 1'b1;
        #1;
        tick();
        drive(32'h0, 24'h0, 1'b0);
        cycles_to_valid(n);
        n_tests++;
        if (n !== 2) begin
            n_fail++;
            $display("FAIL flush_latency: got %0d expected 2", n);
        end
        n_tests++;
        if (i_q !== 32'hE0008000) begin
            n_fail++;
            $display("FAIL flush_next_i: got %h expected %h",
                     i_q, 32'hE0008000);
        end
        tick();
        n_tests++;
        if (i_q_valid !== 1'b1 || i_q !== 32'hFFE6C000) begin
            n_fail++;
            $display("FAIL flush_next_q: got %b/%h expected 1/%h",
                     i_q_valid, i_q, 32'hFFE6C000);
        end
        tick();
    endtask

    task automatic test_async_reset();
        int n;
        i_q_ready = 1'b0;
        drive(32'h8000_0000, 24'hC00000, 1'b1);
        #1;
        tick();
        drive(32'h4000_0000, 24'hC00000, 1'b1);
        tick();
        drive(32'h0, 24'h0, 1'b0);
        cycles_to_valid(n);
        #2;
        reset = 1'b1;
        #1;
        n_tests++;
        if (i_q_valid !== 1'b0 || i_q !== 32'h0) begin
            n_fail++;
            $display("FAIL areset_out: got %b/%h expected 0/0",
                     i_q_valid, i_q);
        end
        tick();
        tick();
        reset = 1'b0;
        i_q_ready = 1'b1;
        drive(32'hC000_0000, 24'hC00000, 1'b1);
        #1;
        tick();
        drive(32'h0, 24'h0, 1'b0);
        cycles_to_valid(n);
        n_tests++;
        if (n !== 2 || i_q !== 32'h00194000) begin
            n_fail++;
            $display("FAIL areset_i: got %0d/%h expected 2/%h",
                     n, i_q, 32'h00194000);
        end
        tick();
        n_tests++;
        if (i_q_valid !== 1'b1 || i_q !== 32'hE0008000) begin
            n_fail++;
            $display("FAIL areset_q: got %b/%h expected 1/%h",
                     i_q_valid, i_q, 32'hE0008000);
        end
        tick();
    endtask

    initial begin
        reset             = 1'b1;
        processing_resetn = 1'b1;
        i_q_ready         = 1'b0;
        drive(32'h0, 24'h0, 1'b0);
        repeat (3) tick();
        test_reset();
        test_join();
        test_vectors();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cn0363_iq_demod.md
# cn0363_iq_demod

Lock-in demodulator for the CN0363 colorimeter pipeline. Joins the excitation phase stream with the ADC sample stream, multiplies each sample by cos/sin of its phase from a quarter-wave sine table, and emits the products as a serial I-then-Q word pair on a valid/ready stream. Sits directly upstream of the DMA sequencer's `i_q` input and the I/Q low-pass filter.

## Interface
- `LUT_ADDR_WIDTH`, 8: quarter-wave table address bits (2^N entries).
- `COEF_WIDTH`, 16: signed coefficient width; full scale 2^(COEF_WIDTH-1)-1.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: sole clock.
- `reset` in 1: asynchronous, active-high reset.
- `processing_resetn` in 1: synchronous active-low flush, driven by the DMA sequencer.
- `phase` in 32: excitation phase, full circle = 2^32.
- `phase_valid` in 1 / `phase_ready` out 1: phase handshake.
- `data` in 24: ADC sample, offset binary.
- `data_valid` in 1 / `data_ready` out 1: sample handshake.
- `i_q` out 32: I word, then Q word.
- `i_q_valid` out 1 / `i_q_ready` in 1: output handshake.

## Operation
- Join: phase and sample accepted together in one cycle. `phase_ready = data_valid & s1_free & processing_resetn`; `data_ready = phase_valid & s1_free & processing_resetn`. Never one without the other.
- Sample conversion: signed = {~data[23], data[22:0]}.
- Angle decode: quadrant = phase[31:30], index = phase[29:30-LUT_ADDR_WIDTH]; low bits truncated.
- Table: entry k = round((2^(COEF_WIDTH-1)-1)·sin(π/2·(k+0.5)/2^N)); half-entry offset, so no 2^N+1 entry exists.
- Quadrant fold for sin: q0 +T[i], q1 +T[~i], q2 −T[i], q3 −T[~i]. cos uses quadrant+1 (mod 4) with the same index.
- Products: I = s·cos, Q = s·sin, full (24+COEF_WIDTH)-bit signed; output word = bits [COEF_WIDTH+23 : COEF_WIDTH-8]. No rounding, no saturation.
- Pipeline stages, each with its own valid bit:
  - S1: index, quadrants, signed sample.
  - S2: registered table outputs with sign applied, plus the sample.
  - OUT: I/Q pair register and word pointer `sel`.
- Stall rule: a stage advances when the next stage is empty or emptying this cycle; `s1_free` follows the same rule.
- OUT behaviour:
  - `i_q = sel ? Q : I`; `i_q_valid = out_valid`.
  - Handshake at sel=0 sets sel=1.
  - Handshake at sel=1 clears `out_valid` and sets sel=0, unless S2 is valid, in which case the pair reloads in the same cycle (no bubble).
- `processing_resetn` low: clears all valid bits and sel; data registers keep their values. Flush has priority over simultaneous handshakes; a half-sent pair is discarded.
- `reset`: asynchronously clears all valid bits, sel and data registers to 0.

## Timing
- Accept in cycle t → I presented from cycle t+3, Q from the cycle after the I handshake.
- Throughput: one pair per 2 cycles with `i_q_ready` held high; inputs then see ready every other cycle at steady state.
- Capacity: three pairs (S1, S2, OUT). The fourth accept is blocked until OUT drains.
- Values after reset: `i_q` = 0, `i_q_valid` = 0, `phase_ready` = 0, `data_ready` = 0.
- `i_q` and `i_q_valid` are stable while `i_q_ready` is low.

## Structure
- Shared package `cn0363_pkg`:
  - `COEF_WIDTH` default.
  - Quadrant encoding constants.
  - Output-slice function.
  - Table-entry generator function used for ROM initialisation.
- Sub-module `cn0363_sin_lut`: quarter-wave ROM with two registered read ports (sin and cos index) and a clock enable tied to the S1→S2 advance.

## Test plan
- phase=0, data=0xC00000 → I=0x1FFF8000 (T[255]=32766), Q=0x00194000 (T[0]=101), first valid 3 cycles after accept.
- phase=0x80000000, data=0xC00000 → I=0xE0008000, Q=0xFFE6C000.
- data=0x800000, any phase → I=Q=0x00000000.
- `i_q_ready` low 10 cycles during 4 offered inputs → exactly 3 accepted, then ready low; on release, order I0 Q0 I1 Q1 I2 Q2, no gaps between pairs.
- `processing_resetn` low for 1 cycle after I0 handshake → `i_q_valid` low next cycle; readys low while flush is asserted; next pair starts with I; Q0 never emitted.
- `reset` pulsed mid-stream asynchronously → outputs 0 immediately; first post-reset pair matches a fresh golden model.
